// File: rtl/seq_ripple_adder_if.sv
// ============================================================================
// Module      : seq_ripple_adder_if
// Description : Operand/result handshake bundle for seq_ripple_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_ripple_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

`default_nettype wire

// File: rtl/seq_ripple_adder.sv
// ============================================================================
// Module      : seq_ripple_adder
// Description : Multi-cycle add/subtract, CHUNK bits per clock through a single
//               ripple stage with a registered inter-chunk carry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_ripple_adder_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_chunk
      $error("seq_ripple_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [IDXW-1:0]    idx_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   res_r;
  logic               carry_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               ovf_r;

  logic [CHUNK-1:0]   chunk_a;
  logic [CHUNK-1:0]   chunk_b;
  logic [CHUNK-1:0]   chunk_s;
  logic [CHUNK:0]     c;
  logic [WIDTH-1:0]   res_next;
  int                 base;

  // One CHUNK-bit ripple slice; c[CHUNK-1] is the carry into the top bit of
  // the slice, which on the last chunk is the carry into the operand MSB.
  always_comb begin
    base     = int'(idx_r) * CHUNK;
    chunk_a  = a_r[base +: CHUNK];
    chunk_b  = b_r[base +: CHUNK];
    chunk_s  = '0;
    c        = '0;
    c[0]     = carry_r;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_s[i] = chunk_a[i] ^ chunk_b[i] ^ c[i];
      c[i+1]     = (chunk_a[i] & chunk_b[i]) | (c[i] & (chunk_a[i] ^ chunk_b[i]));
    end
    res_next              = res_r;
    res_next[base +: CHUNK] = chunk_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r     <= bus.a;
            // Subtraction is a + ~b + ~borrow_in
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.cin ^ bus.sub;
            idx_r   <= '0;
            res_r   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          res_r   <= res_next;
          carry_r <= c[CHUNK];
          idx_r   <= idx_r + 1'b1;
          if (idx_r == LAST_IDX) begin
            sum_r  <= res_next;
            cout_r <= c[CHUNK];
            ovf_r  <= c[CHUNK] ^ c[CHUNK-1];
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;

endmodule

`default_nettype wire
